// File: rtl/prbs_checker_par.sv
// prbs_checker_par
//   Self-synchronising parallel PRBS checker (PRBS7/15/23/31, selectable at
//   run time). Each bit is predicted from previously received bits, so a
//   clean stream locks without seeding. The checker reports bit-error and
//   checked-bit counts for BER measurement.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SEARCH  | counting consecutive clean, non-zero words toward lock
//   LOCKED  | counting errors/bits; consecutive errored words unlock
//
// Ports
//   clk       clock
//   rst       asynchronous reset, active-high
//   prbs_sel  0=x^7+x^6+1, 1=x^15+x^14+1, 2=x^23+x^18+1, 3=x^31+x^28+1
//   data_in   received word, data_in[0] is the earliest-received bit
//   data_vld  data_in valid this cycle
//   cnt_clr   synchronous clear of err_cnt and bit_cnt
//   locked    checker is in LOCKED
//   err_flag  last valid word had at least one error
//   err_cnt   errored bits counted while locked (saturating)
//   bit_cnt   bits checked while locked (saturating)

module prbs_checker_par #(
  parameter int DW         = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       prbs_sel,
  input  logic [DW-1:0]    data_in,
  input  logic             data_vld,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int EW = $clog2(DW + 1);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   clean_run, clean_nxt;
  logic [UW-1:0]   err_run, err_run_nxt;
  logic [30:0]     hist;
  logic [30:0]     hist_nxt;
  logic [1:0]      sel_q;
  logic            sel_chg;

  // Received-bit window: win[30] is the most recent history bit, win[0] the
  // oldest; the new word sits above it with data_in[0] at win[31]. Bit j of
  // the word then finds its n-back tap at win[31+j-n], which may lie inside
  // the same word, so later bits are predicted from earlier ones.
  logic [30+DW:0]  win;
  logic [DW-1:0]   pred7, pred15, pred23, pred31, pred;
  logic [DW-1:0]   err_vec;
  logic [EW-1:0]   err_num;
  logic            qual;
  logic            count_en;
  logic [CNT_W:0]  err_sum;
  logic [CNT_W:0]  bit_sum;

  assign win      = {data_in, hist};
  assign hist_nxt = win[DW+30:DW];

  for (genvar j = 0; j < DW; j++) begin : g_pred
    assign pred7[j]  = win[24+j] ^ win[25+j];
    assign pred15[j] = win[16+j] ^ win[17+j];
    assign pred23[j] = win[8+j]  ^ win[13+j];
    assign pred31[j] = win[j]    ^ win[3+j];
  end

  always_comb begin
    pred = pred7;
    case (prbs_sel)
      2'd0:    pred = pred7;
      2'd1:    pred = pred15;
      2'd2:    pred = pred23;
      default: pred = pred31;
    endcase
  end

  assign err_vec = data_in ^ pred;
  assign err_num = EW'($countones(err_vec));

  // An all-zero history satisfies every recurrence trivially, so a word only
  // counts toward lock if the history it leaves behind is non-zero.
  assign qual    = (err_num == '0) && (hist_nxt != '0);
  assign sel_chg = (prbs_sel != sel_q);

  always_comb begin
    state_nxt   = state;
    clean_nxt   = clean_run;
    err_run_nxt = err_run;
    if (sel_chg) begin
      state_nxt   = S_SEARCH;
      clean_nxt   = '0;
      err_run_nxt = '0;
    end else if (data_vld) begin
      case (state)
        S_SEARCH: begin
          if (qual) begin
            if (clean_run == CW'(LOCK_CNT - 1)) begin
              state_nxt   = S_LOCKED;
              clean_nxt   = '0;
              err_run_nxt = '0;
            end else begin
              clean_nxt = clean_run + CW'(1);
            end
          end else begin
            clean_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (err_num != '0) begin
            if (err_run == UW'(UNLOCK_CNT - 1)) begin
              state_nxt   = S_SEARCH;
              clean_nxt   = '0;
              err_run_nxt = '0;
            end else begin
              err_run_nxt = err_run + UW'(1);
            end
          end else begin
            err_run_nxt = '0;
          end
        end
        default: state_nxt = S_SEARCH;
      endcase
    end
  end

  // The word that arrives with a polynomial change is judged against the
  // wrong recurrence, so it is never counted.
  assign count_en = data_vld && (state == S_LOCKED) && !sel_chg;
  assign err_sum  = {1'b0, err_cnt} + (CNT_W+1)'(err_num);
  assign bit_sum  = {1'b0, bit_cnt} + (CNT_W+1)'(DW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SEARCH;
      clean_run <= '0;
      err_run   <= '0;
      hist      <= '0;
      sel_q     <= '0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      clean_run <= clean_nxt;
      err_run   <= err_run_nxt;
      sel_q     <= prbs_sel;
      if (data_vld) begin
        hist     <= hist_nxt;
        err_flag <= (err_num != '0);
      end
      if (cnt_clr) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else if (count_en) begin
        err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        bit_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
    end
  end

  assign locked = (state == S_LOCKED);

endmodule

// File: doc/prbs_checker_par.md
Name: prbs_checker_par

Overview:
- Parametrised, self-synchronising PRBS checker for the scrambler/descrambler loopback path. It is the receive-side counterpart of the PRBS generators.
- Accepts DW bits per cycle.
- Selects one of PRBS7/15/23/31 at run time.
- Acquires lock with a search/lock state machine and reports bit errors and checked-bit counts for BER measurement.

Parameters:
- DW, 1, bits checked per valid cycle (1..64).
- LOCK_CNT, 16, consecutive clean qualifying words needed to enter LOCKED.
- UNLOCK_CNT, 4, consecutive errored words in LOCKED that force return to SEARCH.
- CNT_W, 32, width of err_cnt and bit_cnt.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- prbs_sel  input  2  polynomial select: 0=x^7+x^6+1, 1=x^15+x^14+1, 2=x^23+x^18+1, 3=x^31+x^28+1.
- data_in  input  DW  received word; data_in[0] is the earliest-received bit.
- data_vld  input  1  data_in valid this cycle.
- cnt_clr  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker in LOCKED state.
- err_flag  output  1  last valid word contained at least one error.
- err_cnt  output  CNT_W  errored bits counted while locked; saturating.
- bit_cnt  output  CNT_W  bits checked while locked; saturating.

Behaviour:
- Reset values: locked=0, err_flag=0, err_cnt=0, bit_cnt=0. Reset also clears the 31-bit history register, the clean/error run counters and the state (SEARCH).
- Prediction: for each received bit b_k with polynomial x^n+x^m+1, pred_k = b_(k-n) XOR b_(k-m).
  - History is taken from received data, not from a local LFSR, so the checker is self-synchronising.
  - Inside a word, later bits use earlier bits of the same word.
- History update: on each valid cycle, the history register shifts in all DW bits. Nothing changes when data_vld=0.
- Word error count: e = popcount(b XOR pred) over the DW bits, width $clog2(DW+1).
  - A single channel bit flip yields exactly 3 errored bits: positions j, j+m and j+n.
- Qualifying word (SEARCH only): e==0 AND the post-update history is nonzero. Consequence: all-zero input never locks.
- SEARCH state:
  - A qualifying word increments clean_run; any other valid word resets clean_run to 0.
  - When clean_run reaches LOCK_CNT, go to LOCKED and zero err_run.
- LOCKED state:
  - A word with e>0 increments err_run; a word with e==0 resets err_run.
  - When err_run reaches UNLOCK_CNT, go to SEARCH and zero clean_run.
- Counting:
  - Only valid words sampled while the state is LOCKED are counted, including the word that causes unlock.
  - Each such word adds e to err_cnt and DW to bit_cnt.
  - Both counters saturate at 2^CNT_W-1 independently.
- cnt_clr: has priority over accumulation in the same cycle. Both counters become 0 and that cycle's contribution is dropped. cnt_clr does not affect state or history.
- prbs_sel change: any change vs its registered copy forces SEARCH with clean_run=0 on the next edge. The word in that cycle is not counted. History is kept.
- Latency: all outputs are registered. err_flag, err_cnt, bit_cnt and locked reflect the word sampled at edge t from edge t+1 onward.
- err_flag: updates only on valid cycles and holds otherwise.
- Asserting rst mid-operation immediately returns all outputs to their reset values, asynchronously.

Test Plan:
1. DW=1, prbs_sel=3, clean PRBS31 stream with data_vld=1 -> locked rises within 31+LOCK_CNT+1 cycles after rst release. err_cnt stays 0. bit_cnt increments by 1 per cycle thereafter.
2. Locked on PRBS31, invert one bit -> err_cnt=3 after 32 more cycles. err_flag pulses on 3 separate valid words. locked stays 1.
3. data_in all-zero, data_vld=1 for 1000 cycles -> locked stays 0; err_cnt=0 and bit_cnt=0.
4. DW=8, locked on PRBS7, then invert every bit for UNLOCK_CNT=4 words -> locked=0 one cycle after the 4th word. err_cnt=sum of e over those 4 words; it then holds.
5. Locked, cnt_clr=1 in the same cycle as an errored word -> err_cnt=0 and bit_cnt=0 next cycle. locked remains 1.
6. Locked on PRBS31, switch prbs_sel to 0 while feeding PRBS7 -> locked=0 next cycle, then relocks within 7+LOCK_CNT+1 words. Assert rst mid-stream -> all outputs 0 immediately.
